// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin arbiter in front of the single memory port; one transaction is owned at a time.
// Optional build macro MEM_ARB_FIXED_PRIO_EN pins the rotation pointer to 0 (lowest index always wins).
module mem_arbiter_rr #(
    parameter int NUM_REQ          = 2,
    parameter int ADDRESS_WIDTH    = 32,
    parameter int CACHE_LINE_WIDTH = 128
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_in,
    input  logic [NUM_REQ-1:0]                    write_in,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]      addr_in,
    input  logic [NUM_REQ*CACHE_LINE_WIDTH-1:0]   data_in,
    input  logic                                  mem_fill_in,
    input  logic [ADDRESS_WIDTH-1:0]              mem_fill_addr_in,
    output logic [NUM_REQ-1:0]                    grant_out,
    output logic [NUM_REQ-1:0]                    done_out,
    output logic                                  busy_out,
    output logic                                  mem_req_out,
    output logic                                  mem_write_out,
    output logic [ADDRESS_WIDTH-1:0]              mem_addr_out,
    output logic [CACHE_LINE_WIDTH-1:0]           mem_data_out
);

    localparam int LINE_OFF = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int OWNER_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [OWNER_W-1:0] LAST_CH = OWNER_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                      r_state;
    logic [OWNER_W-1:0]          r_owner;
    logic [OWNER_W-1:0]          r_rr_ptr;
    logic                        r_write;
    logic [ADDRESS_WIDTH-1:0]    r_addr;
    logic [CACHE_LINE_WIDTH-1:0] r_data;
    logic                        r_mem_req;
    logic                        r_mem_write;
    logic [NUM_REQ-1:0]          r_grant;

    logic [OWNER_W-1:0]          w_winner;
    logic [OWNER_W-1:0]          w_next_ptr;
    logic                        w_any_req;
    logic                        w_fill_hit;
    logic [ADDRESS_WIDTH-1:0]    w_win_addr;
    logic [CACHE_LINE_WIDTH-1:0] w_win_data;
    logic                        w_unused;

    assign w_unused = &{1'b0, mem_fill_addr_in[LINE_OFF-1:0]};

    // Scan from the highest offset down so the channel closest to r_rr_ptr is assigned last and wins.
    always_comb begin
        // NOTE: defaults before the loop keep this purely combinational (no latch when no bit is set).
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_in[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_winner = OWNER_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_any_req  = |req_in;
    assign w_win_addr = addr_in[int'(w_winner) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_win_data = data_in[int'(w_winner) * CACHE_LINE_WIDTH +: CACHE_LINE_WIDTH];

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_next_ptr = '0;
`else
    assign w_next_ptr = (r_owner == LAST_CH) ? '0 : r_owner + OWNER_W'(1);
`endif

    // Completion compares line addresses only; the byte offset within the line is irrelevant.
    assign w_fill_hit = (r_state == ST_WAIT) && mem_fill_in &&
                        (mem_fill_addr_in[ADDRESS_WIDTH-1:LINE_OFF] == r_addr[ADDRESS_WIDTH-1:LINE_OFF]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_grant     <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only the IDLE->ISSUE transition raises them.
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_grant     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_winner;
                        r_write     <= write_in[w_winner];
                        r_addr      <= w_win_addr;
                        r_data      <= w_win_data;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= write_in[w_winner];
                        r_grant     <= ONE_HOT0 << w_winner;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_write) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_fill_hit) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant_out     = r_grant;
    assign done_out      = w_fill_hit ? (ONE_HOT0 << r_owner) : '0;
    assign busy_out      = (r_state != ST_IDLE);
    assign mem_req_out   = r_mem_req;
    assign mem_write_out = r_mem_write;
    assign mem_addr_out  = r_addr;
    assign mem_data_out  = r_data;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: reset, single read, line-match fill, rotation, store, reset mid-wait.
module tb_mem_arbiter_rr;

    logic         clk;
    logic         reset;
    logic [1:0]   req_in;
    logic [1:0]   write_in;
    logic [63:0]  addr_in;
    logic [255:0] data_in;
    logic         mem_fill_in;
    logic [31:0]  mem_fill_addr_in;
    logic [1:0]   grant_out;
    logic [1:0]   done_out;
    logic         busy_out;
    logic         mem_req_out;
    logic         mem_write_out;
    logic [31:0]  mem_addr_out;
    logic [127:0] mem_data_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_grant [4];

    mem_arbiter_rr #(
        .NUM_REQ         (2),
        .ADDRESS_WIDTH   (32),
        .CACHE_LINE_WIDTH(128)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_in          (req_in),
        .write_in        (write_in),
        .addr_in         (addr_in),
        .data_in         (data_in),
        .mem_fill_in     (mem_fill_in),
        .mem_fill_addr_in(mem_fill_addr_in),
        .grant_out       (grant_out),
        .done_out        (done_out),
        .busy_out        (busy_out),
        .mem_req_out     (mem_req_out),
        .mem_write_out   (mem_write_out),
        .mem_addr_out    (mem_addr_out),
        .mem_data_out    (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        reset            = 1'b1;
        req_in           = 2'b00;
        write_in         = 2'b00;
        addr_in          = '0;
        data_in          = '0;
        mem_fill_in      = 1'b0;
        mem_fill_addr_in = '0;

        // T1: requests held during reset are ignored; ch0 wins first after release
        #2;
        reset   = 1'b0;
        req_in  = 2'b11;
        addr_in = {32'h0000_0200, 32'h0000_0100};
        tick();
        tick();
        check("rst_grant", grant_out, 2'b00);
        check("rst_done", done_out, 2'b00);
        check("rst_busy", busy_out, 1'b0);
        check("rst_mem_req", mem_req_out, 1'b0);
        check("rst_mem_write", mem_write_out, 1'b0);
        check("rst_mem_addr", mem_addr_out, 32'h0);
        check("rst_mem_data", mem_data_out, 128'h0);
        reset = 1'b1;
        tick();
        check("t1_grant", grant_out, 2'b01);
        check("t1_mem_req", mem_req_out, 1'b1);
        check("t1_mem_addr", mem_addr_out, 32'h0000_0100);
        req_in = 2'b00;
        tick();
        check("t1_wait_req", mem_req_out, 1'b0);
        check("t1_wait_busy", busy_out, 1'b1);
        mem_fill_in      = 1'b1;
        mem_fill_addr_in = 32'h0000_0100;
        #1;
        check("t1_done", done_out, 2'b01);
        tick();
        mem_fill_in = 1'b0;
        check("t1_idle", busy_out, 1'b0);

        // T2: single ch1 read, fill five cycles after the request
        req_in   = 2'b10;
        write_in = 2'b00;
        addr_in  = {32'h0000_1000, 32'h0000_0100};
        tick();
        check("t2_mem_req", mem_req_out, 1'b1);
        check("t2_mem_write", mem_write_out, 1'b0);
        check("t2_mem_addr", mem_addr_out, 32'h0000_1000);
        check("t2_grant", grant_out, 2'b10);
        req_in = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_waiting", {busy_out, done_out}, 3'b100);
        end
        mem_fill_in      = 1'b1;
        mem_fill_addr_in = 32'h0000_1000;
        #1;
        check("t2_done", done_out, 2'b10);
        tick();
        mem_fill_in = 1'b0;
        check("t2_idle", busy_out, 1'b0);

        // T4: both channels reading continuously
        req_in  = 2'b11;
        addr_in = {32'h0000_4000, 32'h0000_3000};
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_grant%0d", k), grant_out, exp_grant[k]);
            tick();
            mem_fill_in      = 1'b1;
            mem_fill_addr_in = (exp_grant[k] == 2'b01) ? 32'h0000_3000 : 32'h0000_4000;
            #1;
            check($sformatf("t4_done%0d", k), done_out, exp_grant[k]);
            tick();
            mem_fill_in = 1'b0;
            if (k == 3) req_in = 2'b00;
            check($sformatf("t4_idle%0d", k), busy_out, 1'b0);
            tick();
        end

        // T3: fill to another line is ignored, fill within the same line completes
        req_in  = 2'b01;
        addr_in = {32'h0000_4000, 32'h0000_1000};
        tick();
        check("t3_grant", grant_out, 2'b01);
        req_in = 2'b00;
        tick();
        mem_fill_in      = 1'b1;
        mem_fill_addr_in = 32'h0000_2040;
        #1;
        check("t3_miss_done", done_out, 2'b00);
        tick();
        check("t3_miss_busy", busy_out, 1'b1);
        mem_fill_addr_in = 32'h0000_100C;
        #1;
        check("t3_hit_done", done_out, 2'b01);
        tick();
        mem_fill_in = 1'b0;
        check("t3_idle", busy_out, 1'b0);

        // T5: ch0 store is fire-and-forget, pending ch1 read issues two cycles later
        req_in   = 2'b01;
        write_in = 2'b01;
        addr_in  = {32'h0000_5000, 32'h0000_0040};
        data_in  = {128'h1111_2222, 128'hDEAD_BEEF};
        tick();
        check("t5_st_grant", grant_out, 2'b01);
        check("t5_st_req", mem_req_out, 1'b1);
        check("t5_st_write", mem_write_out, 1'b1);
        check("t5_st_addr", mem_addr_out, 32'h0000_0040);
        check("t5_st_data", mem_data_out, 128'hDEAD_BEEF);
        req_in   = 2'b10;
        write_in = 2'b00;
        tick();
        check("t5_gap", {mem_req_out, busy_out, done_out}, 4'b0000);
        check("t5_data_hold", mem_data_out, 128'hDEAD_BEEF);
        tick();
        check("t5_rd_grant", grant_out, 2'b10);
        check("t5_rd_req", mem_req_out, 1'b1);
        check("t5_rd_write", mem_write_out, 1'b0);
        check("t5_rd_addr", mem_addr_out, 32'h0000_5000);
        req_in = 2'b00;
        tick();

        // T6: reset while waiting abandons the read; its late fill is ignored
        check("t6_pre_busy", busy_out, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_rst_busy", busy_out, 1'b0);
        check("t6_rst_addr", mem_addr_out, 32'h0);
        tick();
        reset            = 1'b1;
        mem_fill_in      = 1'b1;
        mem_fill_addr_in = 32'h0000_5000;
        #1;
        check("t6_fill_done", done_out, 2'b00);
        tick();
        mem_fill_in = 1'b0;
        check("t6_idle", {busy_out, mem_req_out, grant_out}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
